// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the two-input gate BIST.
package gate_bist_pkg;
  localparam int unsigned NUM_VECTORS = 4;
  localparam int unsigned SETTLE_W    = 4;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_e;
endpackage

// File: rtl/gate_bist_if.sv
// Control, result and gate-under-test signals of gate_bist, bundled for port use.
interface gate_bist_if;
  import gate_bist_pkg::*;

  logic                   start;
  logic                   abort;
  logic [NUM_VECTORS-1:0] truthTable;
  logic                   dutA;
  logic                   dutB;
  logic                   dutOut;
  logic                   busy;
  logic                   done;
  logic                   allPassed;
  logic [NUM_VECTORS-1:0] failMask;
  logic [1:0]             vecIndex;

  modport master (
    output start, abort, truthTable, dutOut,
    input  dutA, dutB, busy, done, allPassed, failMask, vecIndex
  );

  modport slave (
    input  start, abort, truthTable, dutOut,
    output dutA, dutB, busy, done, allPassed, failMask, vecIndex
  );
endinterface

// File: rtl/gate_bist_settle_timer.sv
// Loadable down-counter that times how long each vector is held before sampling.
module settle_timer
  import gate_bist_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [SETTLE_W-1:0] load_val_i,
  input  logic                dec_i,
  output logic                zero_o
);
  logic [SETTLE_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/gate_bist.sv
// Exhaustive 2-input gate tester: steps all four input vectors, holds each SETTLE
// cycles, and compares the gate output against a captured truth table.
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input logic        clk,
  input logic        resetN,
  gate_bist_if.slave bus
);
  localparam logic [SETTLE_W-1:0] RELOAD   = SETTLE_W'(SETTLE - 1);
  localparam logic [1:0]          LAST_VEC = 2'(NUM_VECTORS - 1);

  state_e                 state_q;
  logic [NUM_VECTORS-1:0] tt_q;
  logic [NUM_VECTORS-1:0] fail_q;
  logic [NUM_VECTORS-1:0] fail_d;
  logic [1:0]             idx_q;
  logic                   dut_a_q;
  logic                   dut_b_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   all_q;

  logic                   tmr_load;
  logic [SETTLE_W-1:0]    tmr_val;
  logic                   tmr_dec;
  logic                   tmr_zero;
  logic                   mismatch;

  settle_timer u_settle (
    .clk       (clk),
    .rst_n     (resetN),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .dec_i     (tmr_dec),
    .zero_o    (tmr_zero)
  );

  always_comb begin
    // Case inequality so an X/Z gate output counts as a failure in simulation.
    mismatch = (bus.dutOut !== tt_q[idx_q]);
    fail_d   = fail_q | (NUM_VECTORS'(mismatch) << idx_q);

    tmr_load = 1'b0;
    tmr_val  = RELOAD;
    tmr_dec  = 1'b0;
    if (bus.abort) begin
      tmr_load = 1'b1;
      tmr_val  = '0;
    end else begin
      case (state_q)
        IDLE, DONE: tmr_load = bus.start;
        DRIVE: begin
          if (!tmr_zero)             tmr_dec  = 1'b1;
          else if (idx_q != LAST_VEC) tmr_load = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      tt_q    <= '0;
      fail_q  <= '0;
      idx_q   <= '0;
      dut_a_q <= 1'b0;
      dut_b_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      all_q   <= 1'b0;
    end else if (bus.abort) begin
      state_q <= IDLE;
      fail_q  <= '0;
      idx_q   <= '0;
      dut_a_q <= 1'b0;
      dut_b_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      all_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q <= DRIVE;
            tt_q    <= bus.truthTable;
            fail_q  <= '0;
            idx_q   <= '0;
            dut_a_q <= 1'b0;
            dut_b_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            all_q   <= 1'b0;
          end
        end
        DRIVE: begin
          if (tmr_zero) begin
            fail_q <= fail_d;
            if (idx_q == LAST_VEC) begin
              state_q <= DONE;
              dut_a_q <= 1'b0;
              dut_b_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              all_q   <= (fail_d == '0);
            end else begin
              idx_q              <= idx_q + 2'd1;
              {dut_a_q, dut_b_q} <= idx_q + 2'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dutA      = dut_a_q;
  assign bus.dutB      = dut_b_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.allPassed = all_q;
  assign bus.failMask  = fail_q;
  assign bus.vecIndex  = idx_q;
endmodule
